// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller: edge/level pending capture, masking,
// and a claim/complete handshake exposed as four word registers.
module int_ctrl #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             Clk,
  input  logic             sys_rstn,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic             RE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] IrqIn,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] prev_in;
  logic [2:0]       cur_id;

  logic [N_SRC-1:0] eligible;
  logic [2:0]       win;
  logic             claim_fire;
  logic             complete_fire;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] pending_nxt;
  logic             unused_din;

  assign unused_din = ^Din[31:N_SRC];

  assign eligible = pending & mask;

  always_comb begin
    win = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (eligible[i-1]) win = 3'(i - 1);
    end
  end

  assign claim_fire    = (state == S_ASSERT) && RE && (Addr == 2'd3);
  assign complete_fire = (state == S_SERVICE) && WE && (Addr == 2'd3) && (Din[2:0] == cur_id);

  // Edge sources: a fresh edge beats a same-cycle W1C or claim clear.
  // Level sources simply follow the input and ignore both clears.
  always_comb begin
    w1c         = (WE && (Addr == 2'd0)) ? Din[N_SRC-1:0] : '0;
    claim_clr   = claim_fire ? (N_SRC'(1) << win) : '0;
    edge_set    = IrqIn & ~prev_in;
    pending_nxt = (mode & IrqIn) |
                  (~mode & (edge_set | (pending & ~(w1c | claim_clr))));
  end

  always_ff @(posedge Clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state   <= S_IDLE;
      IRQ     <= 1'b0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      prev_in <= '0;
      cur_id  <= '0;
    end else begin
      prev_in <= IrqIn;
      pending <= pending_nxt;
      if (WE && (Addr == 2'd1)) mask <= Din[N_SRC-1:0];
      if (WE && (Addr == 2'd2)) mode <= Din[N_SRC-1:0];

      case (state)
        S_IDLE: begin
          if (|eligible) begin
            state <= S_ASSERT;
            IRQ   <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (claim_fire) begin
            state  <= S_SERVICE;
            IRQ    <= 1'b0;
            cur_id <= win;
          end else if (~|eligible) begin
            state <= S_IDLE;
            IRQ   <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (complete_fire) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          IRQ   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      2'd0: Dout[N_SRC-1:0] = pending;
      2'd1: Dout[N_SRC-1:0] = mask;
      2'd2: Dout[N_SRC-1:0] = mode;
      default: begin
        if (state == S_ASSERT) Dout = {1'b1, 28'b0, win};
      end
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_int_ctrl;

  localparam int unsigned N_SRC = 6;

  logic             Clk;
  logic             sys_rstn;
  logic [1:0]       Addr;
  logic             WE;
  logic             RE;
  logic [31:0]      Din;
  logic [31:0]      Dout;
  logic [N_SRC-1:0] IrqIn;
  logic             IRQ;

  int n_cmp;
  int n_fail;

  string       tag_q[$];
  logic [31:0] val_q[$];

  int_ctrl #(.N_SRC(N_SRC)) dut (
    .Clk      (Clk),
    .sys_rstn (sys_rstn),
    .Addr     (Addr),
    .WE       (WE),
    .RE       (RE),
    .Din      (Din),
    .Dout     (Dout),
    .IrqIn    (IrqIn),
    .IRQ      (IRQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (val_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed %h required <queued value>", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push_exp(tag, {31'b0, exp});
    pop_cmp({31'b0, IRQ});
  endtask

  // Register read with RE asserted through the next rising edge.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    Addr = a;
    RE   = 1'b1;
    push_exp(tag, exp);
    #1;
    pop_cmp(Dout);
    tick();
    RE = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
    Addr = a;
    push_exp(tag, exp);
    #1;
    pop_cmp(Dout);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE  = 1'b0;
    Din = '0;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] v);
    IrqIn = v;
    tick();
    IrqIn = '0;
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    sys_rstn = 1'b0;
    Addr     = '0;
    WE       = 1'b0;
    RE       = 1'b0;
    Din      = '0;
    IrqIn    = '0;
    repeat (3) tick();
    sys_rstn = 1'b1;
    tick();

    // Reset state
    chk_irq("rst_irq", 1'b0);
    peek(2'd0, 32'h0, "rst_pending");
    peek(2'd1, 32'h0, "rst_mask");
    peek(2'd2, 32'h0, "rst_mode");
    peek(2'd3, 32'h0, "rst_claim");

    // 1: single edge on source 1
    wr(2'd1, 32'h3F);
    peek(2'd1, 32'h3F, "t1_mask");
    pulse(6'b000010);
    chk_irq("t1_irq_after_k", 1'b0);
    rd(2'd0, 32'h2, "t1_pending");
    chk_irq("t1_irq_after_k1", 1'b1);
    rd(2'd3, 32'h8000_0001, "t1_claim");
    chk_irq("t1_irq_service", 1'b0);
    rd(2'd0, 32'h0, "t1_pending_cleared");
    wr(2'd3, 32'h1);
    tick();
    chk_irq("t1_idle", 1'b0);

    // 2: simultaneous sources 3 and 1, priority then complete
    pulse(6'b001010);
    tick();
    chk_irq("t2_irq", 1'b1);
    rd(2'd3, 32'h8000_0001, "t2_claim1");
    rd(2'd0, 32'h8, "t2_pending");
    chk_irq("t2_irq_service", 1'b0);
    wr(2'd3, 32'h1);
    chk_irq("t2_irq_after_complete", 1'b0);
    tick();
    chk_irq("t2_irq_reassert", 1'b1);
    rd(2'd3, 32'h8000_0003, "t2_claim3");
    wr(2'd3, 32'h3);

    // 3: masked pending stays silent until unmasked
    wr(2'd1, 32'h0);
    pulse(6'b000100);
    rd(2'd0, 32'h4, "t3_pending");
    for (int i = 0; i < 20; i++) begin
      chk_irq("t3_masked_irq", 1'b0);
      tick();
    end
    wr(2'd1, 32'h4);
    chk_irq("t3_irq_at_mask_edge", 1'b0);
    tick();
    chk_irq("t3_irq_unmasked", 1'b1);
    rd(2'd3, 32'h8000_0002, "t3_claim");
    wr(2'd3, 32'h2);

    // 4: level mode on source 0
    wr(2'd2, 32'h1);
    wr(2'd1, 32'h1);
    IrqIn = 6'b000001;
    tick();
    tick();
    chk_irq("t4_irq", 1'b1);
    rd(2'd3, 32'h8000_0000, "t4_claim");
    chk_irq("t4_irq_service", 1'b0);
    rd(2'd0, 32'h1, "t4_level_pending");
    wr(2'd3, 32'h0);
    tick();
    chk_irq("t4_irq_reassert", 1'b1);
    IrqIn = '0;
    tick();
    rd(2'd0, 32'h0, "t4_pending_dropped");
    chk_irq("t4_irq_dropped", 1'b0);
    peek(2'd3, 32'h0, "t4_claim_idle");

    // 5: W1C racing a new edge
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h3F);
    pulse(6'b000010);
    tick();
    chk_irq("t5_irq", 1'b1);
    IrqIn = 6'b000010;
    wr(2'd0, 32'h2);
    IrqIn = '0;
    rd(2'd0, 32'h2, "t5_pending_set_wins");
    chk_irq("t5_irq_held", 1'b1);
    wr(2'd0, 32'h2);
    peek(2'd0, 32'h0, "t5_pending_w1c");
    tick();
    chk_irq("t5_irq_dropped", 1'b0);

    // 6: mismatched complete, then asynchronous reset mid-service
    pulse(6'b000010);
    tick();
    rd(2'd3, 32'h8000_0001, "t6_claim");
    wr(2'd3, 32'h2);
    chk_irq("t6_irq_mismatch", 1'b0);
    peek(2'd3, 32'h0, "t6_claim_service");
    wr(2'd2, 32'h20);
    pulse(6'b010000);
    wr(2'd3, 32'h2);
    peek(2'd0, 32'h10, "t6_pending_in_service");
    chk_irq("t6_irq_still_service", 1'b0);
    @(negedge Clk);
    sys_rstn = 1'b0;
    #1;
    chk_irq("t6_rst_irq", 1'b0);
    peek(2'd0, 32'h0, "t6_rst_pending");
    peek(2'd1, 32'h0, "t6_rst_mask");
    peek(2'd2, 32'h0, "t6_rst_mode");
    tick();
    sys_rstn = 1'b1;
    tick();
    chk_irq("t6_post_rst_irq", 1'b0);

    if (val_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", val_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
